// File: rtl/mac_mgnt_pkg.sv
// Shared definitions for the management-bus arbiter: FSM encoding and beat counting.
package mac_mgnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Up to 8 beats per transaction, so 3 bits plus a carry bit.
    localparam int BEAT_W = 4;
    typedef logic [BEAT_W-1:0] beat_t;

    function automatic beat_t beat_target(input logic [2:0] len);
        return {1'b0, len} + beat_t'(1);
    endfunction

endpackage

// File: rtl/mac_mgnt_arb_rr_arb.sv
// Combinational round-robin selector: first set request at or after rr_ptr_i, cyclically.
module rr_arb #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    rr_ptr_i,
    output logic [N_REQ-1:0] grant_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PW'((int'(rr_ptr_i) + i) % N_REQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_mgnt_arb.sv
// Arbitrates N_REQ management requesters onto the single mac_ctrl management bus,
// one transaction at a time, with round-robin fairness and an idle timeout.
module mac_mgnt_arb
    import mac_mgnt_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rstn_sys,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_wr,
    input  logic [N_REQ*8-1:0] req_addr,
    input  logic [N_REQ*3-1:0] req_len,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_data_valid,
    output logic [N_REQ-1:0]   req_ack,
    output logic [7:0]         resp_data,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [N_REQ-1:0]   req_done,
    output logic [N_REQ-1:0]   req_err,
    output logic               sys_req_valid,
    output logic               sys_req_wr,
    output logic [7:0]         sys_req_addr,
    input  logic               sys_req_ack,
    output logic [7:0]         sys_req_data,
    output logic               sys_req_data_valid,
    input  logic [7:0]         sys_resp_data,
    input  logic               sys_resp_data_valid
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    state_e           state_q;
    logic [N_REQ-1:0] owner_oh_q;
    logic [N_REQ-1:0] done_q;
    logic [N_REQ-1:0] err_q;
    logic [PW-1:0]    rr_ptr_q;
    logic             wr_q;
    logic [7:0]       addr_q;
    logic [2:0]       len_q;
    beat_t            beat_q;
    beat_t            beat_d;
    logic [IW-1:0]    idle_q;

    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    owner_idx;
    logic [PW-1:0]    next_ptr;
    logic             sel_wr;
    logic [7:0]       sel_addr;
    logic [2:0]       sel_len;
    logic [7:0]       own_data;
    logic             in_req;
    logic             in_data;
    logic             bus_open;
    logic             own_strobe;
    logic             beat;
    logic             last_beat;
    logic             timeout_hit;

    rr_arb #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_arb (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (grant)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        own_data  = '0;
        owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_wr   = req_wr[i];
                sel_addr = req_addr[i*8 +: 8];
                sel_len  = req_len[i*3 +: 3];
            end
            if (owner_oh_q[i]) begin
                own_data  = req_data[i*8 +: 8];
                owner_idx = PW'(i);
            end
        end
    end

    // The data phase opens on the ack cycle itself so beats riding with the ack count.
    assign in_req      = (state_q == ST_REQ);
    assign in_data     = (state_q == ST_DATA);
    assign bus_open    = in_data || (in_req && sys_req_ack);
    assign own_strobe  = |(req_data_valid & owner_oh_q);
    assign beat        = bus_open && (wr_q ? own_strobe : sys_resp_data_valid);
    assign beat_d      = beat_q + beat_t'(beat);
    assign last_beat   = beat && (beat_d == beat_target(len_q));
    assign timeout_hit = (idle_q == IW'(TIMEOUT));
    assign next_ptr    = (owner_idx == PW'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;

    assign sys_req_valid      = in_req;
    assign sys_req_wr         = in_req && wr_q;
    assign sys_req_addr       = in_req ? addr_q : '0;
    assign sys_req_data       = (wr_q && bus_open) ? own_data : '0;
    assign sys_req_data_valid = wr_q && bus_open && own_strobe;
    assign req_ack            = in_req  ? (owner_oh_q & {N_REQ{sys_req_ack}}) : '0;
    assign resp_valid         = in_data ? (owner_oh_q & {N_REQ{sys_resp_data_valid}}) : '0;
    assign resp_data          = in_data ? sys_resp_data : '0;
    assign req_done           = done_q;
    assign req_err            = err_q;

    always_ff @(posedge clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state_q    <= ST_IDLE;
            owner_oh_q <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rr_ptr_q   <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            idle_q     <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        owner_oh_q <= grant;
                        wr_q       <= sel_wr;
                        addr_q     <= sel_addr;
                        len_q      <= sel_len;
                        beat_q     <= '0;
                        idle_q     <= '0;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ, ST_DATA: begin
                    if ((in_req && sys_req_ack) || beat) begin
                        idle_q <= '0;
                        beat_q <= beat_d;
                        if (last_beat) begin
                            done_q  <= owner_oh_q;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end else if (timeout_hit) begin
                        err_q   <= owner_oh_q;
                        state_q <= ST_DONE;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    rr_ptr_q <= next_ptr;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_mgnt_arb.sv
// Directed scoreboard bench for mac_mgnt_arb: stimulus queues the expected bus events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mac_mgnt_arb;

    localparam int N   = 4;
    localparam int TMO = 15;

    localparam int EV_REQ   = 0;
    localparam int EV_WDATA = 1;
    localparam int EV_RDATA = 2;
    localparam int EV_DONE  = 3;
    localparam int EV_ERR   = 4;

    typedef struct {
        int          kind;
        logic [15:0] val;
        int          lat;
    } ev_t;

    logic           clk                 = 1'b0;
    logic           rstn_sys            = 1'b0;
    logic [N-1:0]   req_valid           = '0;
    logic [N-1:0]   req_wr              = '0;
    logic [N*8-1:0] req_addr            = '0;
    logic [N*3-1:0] req_len             = '0;
    logic [N*8-1:0] req_data            = '0;
    logic [N-1:0]   req_data_valid      = '0;
    logic           sys_req_ack         = 1'b0;
    logic [7:0]     sys_resp_data       = '0;
    logic           sys_resp_data_valid = 1'b0;
    logic [N-1:0]   req_ack;
    logic [7:0]     resp_data;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   req_done;
    logic [N-1:0]   req_err;
    logic           sys_req_valid;
    logic           sys_req_wr;
    logic [7:0]     sys_req_addr;
    logic [7:0]     sys_req_data;
    logic           sys_req_data_valid;

    ev_t  sb[$];
    int   total     = 0;
    int   bad       = 0;
    int   cyc       = 0;
    int   stimCycle = 0;
    int   reqCyc    = 0;
    logic prevValid = 1'b0;

    mac_mgnt_arb #(
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk                 (clk),
        .rstn_sys            (rstn_sys),
        .req_valid           (req_valid),
        .req_wr              (req_wr),
        .req_addr            (req_addr),
        .req_len             (req_len),
        .req_data            (req_data),
        .req_data_valid      (req_data_valid),
        .req_ack             (req_ack),
        .resp_data           (resp_data),
        .resp_valid          (resp_valid),
        .req_done            (req_done),
        .req_err             (req_err),
        .sys_req_valid       (sys_req_valid),
        .sys_req_wr          (sys_req_wr),
        .sys_req_addr        (sys_req_addr),
        .sys_req_ack         (sys_req_ack),
        .sys_req_data        (sys_req_data),
        .sys_req_data_valid  (sys_req_data_valid),
        .sys_resp_data       (sys_resp_data),
        .sys_resp_data_valid (sys_resp_data_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushEv(input int kind, input logic [15:0] val, input int lat);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [15:0] val, input int lat);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected event: got kind=%0d val=%0h, expected no event", kind, val);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val !== val || (e.lat >= 0 && e.lat != lat)) begin
                bad++;
                $display("[TB] FAIL scoreboard: got kind=%0d val=%0h lat=%0d, expected kind=%0d val=%0h lat=%0d",
                         kind, val, lat, e.kind, e.val, e.lat);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rstn_sys) begin
            if (sys_req_valid && !prevValid) begin
                observe(EV_REQ, {7'b0, sys_req_wr, sys_req_addr}, cyc - stimCycle);
                reqCyc = cyc;
            end
            if (sys_req_data_valid)
                observe(EV_WDATA, {8'b0, sys_req_data}, -1);
            if (|resp_valid)
                observe(EV_RDATA, {4'b0, resp_valid, resp_data}, -1);
            if (|req_done)
                observe(EV_DONE, {12'b0, req_done}, cyc - reqCyc);
            if (|req_err)
                observe(EV_ERR, {12'b0, req_err}, cyc - reqCyc);
        end
        prevValid = sys_req_valid;
    end

    task automatic expectXfer(input int owner, input logic wr, input logic [7:0] addr,
                              input int nBeats, input logic [63:0] bytes, input int reqLat);
        logic [3:0] oh;
        oh = 4'b0001 << owner;
        pushEv(EV_REQ, {7'b0, wr, addr}, reqLat);
        for (int k = 0; k < nBeats; k++) begin
            if (wr) pushEv(EV_WDATA, {8'b0, bytes[8*k +: 8]}, -1);
            else    pushEv(EV_RDATA, {4'b0, oh, bytes[8*k +: 8]}, -1);
        end
        pushEv(EV_DONE, {12'b0, oh}, -1);
    endtask

    task automatic setReq(input int idx, input logic wr, input logic [7:0] addr, input logic [2:0] len);
        req_wr[idx]           = wr;
        req_addr[idx*8 +: 8]  = addr;
        req_len[idx*3 +: 3]   = len;
        req_valid[idx]        = 1'b1;
        stimCycle             = cyc;
    endtask

    task automatic driveBeat(input int owner, input logic wr, input logic [7:0] b);
        if (wr) begin
            req_data               = {N{8'hEE}};
            req_data[owner*8 +: 8] = b;
            req_data_valid         = '1;
        end else begin
            sys_resp_data       = b;
            sys_resp_data_valid = 1'b1;
        end
    endtask

    task automatic clearBeat();
        req_data_valid      = '0;
        sys_resp_data_valid = 1'b0;
    endtask

    task automatic waitReqValid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sys_req_valid) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL grantWait: got no sys_req_valid in 20 cycles, expected a grant");
        end
    endtask

    // Drives one granted transaction; always follows it with one surplus beat.
    task automatic applyStimulus(input int owner, input logic wr, input int nBeats, input int ackDelay,
                                 input bit beatWithAck, input logic [63:0] bytes);
        bit ok;
        int k;
        waitReqValid(ok);
        if (!ok) return;
        req_valid[owner] = 1'b0;
        tick(ackDelay);
        sys_req_ack = 1'b1;
        k = 0;
        if (beatWithAck && wr) begin
            driveBeat(owner, wr, bytes[7:0]);
            k = 1;
        end
        tick(1);
        sys_req_ack = 1'b0;
        while (k < nBeats) begin
            driveBeat(owner, wr, bytes[8*k +: 8]);
            tick(1);
            k++;
        end
        driveBeat(owner, wr, 8'hEE);
        tick(1);
        clearBeat();
        tick(2);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".req_ack"},       32'(req_ack), 32'h0);
        checkOutput({tag, ".resp_data"},     32'(resp_data), 32'h0);
        checkOutput({tag, ".resp_valid"},    32'(resp_valid), 32'h0);
        checkOutput({tag, ".req_done"},      32'(req_done), 32'h0);
        checkOutput({tag, ".req_err"},       32'(req_err), 32'h0);
        checkOutput({tag, ".sys_req_valid"}, 32'(sys_req_valid), 32'h0);
        checkOutput({tag, ".sys_req_wr"},    32'(sys_req_wr), 32'h0);
        checkOutput({tag, ".sys_req_addr"},  32'(sys_req_addr), 32'h0);
        checkOutput({tag, ".sys_req_data"},  32'(sys_req_data), 32'h0);
        checkOutput({tag, ".sys_req_dv"},    32'(sys_req_data_valid), 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        bit errSeen;

        // Reset holds every output low even with all requesters active.
        req_valid = '1;
        sys_resp_data = 8'h5C;
        tick(2);
        checkAllZero("reset");
        req_valid = '0;
        sys_resp_data = '0;
        rstn_sys = 1'b1;
        tick(2);

        $display("[TB] requesters 1 and 3 together from rr_ptr=0");
        expectXfer(1, 1'b0, 8'h31, 1, 64'h5A, 1);
        expectXfer(3, 1'b1, 8'h33, 1, 64'hC3, -1);
        setReq(1, 1'b0, 8'h31, 3'd0);
        setReq(3, 1'b1, 8'h33, 3'd0);
        applyStimulus(1, 1'b0, 1, 0, 1'b0, 64'h5A);
        applyStimulus(3, 1'b1, 1, 0, 1'b1, 64'hC3);

        $display("[TB] pointer wrapped to 0: requester 0 beats requester 3");
        expectXfer(0, 1'b0, 8'h01, 1, 64'h10, 1);
        expectXfer(3, 1'b0, 8'h03, 1, 64'h30, -1);
        setReq(0, 1'b0, 8'h01, 3'd0);
        setReq(3, 1'b0, 8'h03, 3'd0);
        applyStimulus(0, 1'b0, 1, 0, 1'b0, 64'h10);
        applyStimulus(3, 1'b0, 1, 0, 1'b0, 64'h30);

        $display("[TB] write from requester 2, ack after 3 cycles");
        expectXfer(2, 1'b1, 8'h10, 2, 64'h55AA, 1);
        setReq(2, 1'b1, 8'h10, 3'd1);
        applyStimulus(2, 1'b1, 2, 3, 1'b1, 64'h55AA);

        $display("[TB] read of 4 beats from requester 0");
        expectXfer(0, 1'b0, 8'h20, 4, 64'h44332211, 1);
        setReq(0, 1'b0, 8'h20, 3'd3);
        applyStimulus(0, 1'b0, 4, 1, 1'b0, 64'h44332211);

        $display("[TB] timeout on requester 1, then requester 2 served");
        pushEv(EV_REQ, {7'b0, 1'b1, 8'h50}, 1);
        pushEv(EV_ERR, 16'h0002, TMO + 1);
        expectXfer(2, 1'b0, 8'h60, 2, 64'h6665, -1);
        setReq(1, 1'b1, 8'h50, 3'd0);
        setReq(2, 1'b0, 8'h60, 3'd1);
        waitReqValid(ok);
        req_valid[1] = 1'b0;
        errSeen = 1'b0;
        for (int i = 0; i < 40 && !errSeen; i++) begin
            tick(1);
            errSeen = |req_err;
        end
        checkOutput("errSeen", 32'(errSeen), 32'h1);
        applyStimulus(2, 1'b0, 2, 0, 1'b0, 64'h6665);

        $display("[TB] reset asserted in the data phase");
        pushEv(EV_REQ, {7'b0, 1'b0, 8'h40}, 1);
        pushEv(EV_RDATA, {4'b0, 4'b0001, 8'h71}, -1);
        setReq(0, 1'b0, 8'h40, 3'd3);
        waitReqValid(ok);
        req_valid[0] = 1'b0;
        sys_req_ack = 1'b1;
        tick(1);
        sys_req_ack = 1'b0;
        driveBeat(0, 1'b0, 8'h71);
        tick(1);
        clearBeat();
        #3;
        driveBeat(0, 1'b0, 8'h72);
        rstn_sys = 1'b0;
        #1;
        checkAllZero("midReset");
        clearBeat();
        tick(2);
        rstn_sys = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("postReset.doneErr", 32'({req_done, req_err}), 32'h0);
            checkOutput("postReset.sysValid", 32'(sys_req_valid), 32'h0);
            tick(1);
        end

        $display("[TB] after reset: pointer back at 0, surplus fifth write beat dropped");
        expectXfer(0, 1'b1, 8'h0C, 4, 64'h04030201, 1);
        expectXfer(3, 1'b0, 8'h0D, 1, 64'h99, -1);
        setReq(0, 1'b1, 8'h0C, 3'd3);
        setReq(3, 1'b0, 8'h0D, 3'd0);
        applyStimulus(0, 1'b1, 4, 1, 1'b0, 64'h04030201);
        applyStimulus(3, 1'b0, 1, 0, 1'b0, 64'h99);

        tick(4);
        checkOutput("scoreboardDrained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_mgnt_arb.md
MAC_MGNT_ARB -- requirements
Module: mac_mgnt_arb

Parameters
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of management requesters, legal range 2..8.
REQ-002 The block SHALL have parameter TIMEOUT, default 1023, giving the idle-cycle limit before an owned transaction is aborted.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, the only clock in the block.
REQ-004 The block SHALL have port rstn_sys, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, N_REQ bits: per-requester transaction request.
REQ-006 The block SHALL have port req_wr, input, N_REQ bits: per-requester write (1) or read (0).
REQ-007 The block SHALL have port req_addr, input, N_REQ*8 bits: packed register address per requester.
REQ-008 The block SHALL have port req_len, input, N_REQ*3 bits: packed byte count minus 1 (1..8 bytes).
REQ-009 The block SHALL have port req_data, input, N_REQ*8 bits: packed write data.
REQ-010 The block SHALL have port req_data_valid, input, N_REQ bits: write byte strobe.
REQ-011 The block SHALL have port req_ack, output, N_REQ bits: sys_req_ack routed to the owner only.
REQ-012 The block SHALL have port resp_data, output, 8 bits: sys_resp_data broadcast to all requesters.
REQ-013 The block SHALL have port resp_valid, output, N_REQ bits: sys_resp_data_valid routed to the owner only.
REQ-014 The block SHALL have port req_done, output, N_REQ bits: one-cycle pulse when a transaction completes.
REQ-015 The block SHALL have port req_err, output, N_REQ bits: one-cycle pulse when a transaction is aborted on timeout.
REQ-016 The block SHALL have ports sys_req_valid (output, 1), sys_req_wr (output, 1), sys_req_addr (output, 8), sys_req_ack (input, 1), sys_req_data (output, 8), sys_req_data_valid (output, 1), sys_resp_data (input, 8) and sys_resp_data_valid (input, 1): the shared management bus toward mac_ctrl.

Function
REQ-017 The block SHALL implement FSM states IDLE, REQ, DATA and DONE.
REQ-018 In IDLE, when any req_valid bit is set, the block SHALL select the owner by round-robin starting at rr_ptr, latch the owner's wr, addr and len, and enter REQ on the next cycle.
REQ-019 In REQ, the block SHALL drive sys_req_valid=1 with the latched wr and addr, and on sys_req_ack=1 it SHALL deassert sys_req_valid in the same cycle and enter DATA.
REQ-020 In DATA for a write, the block SHALL forward the owner's req_data and req_data_valid to the bus, ignore all other requesters' strobes, and count beats.
REQ-021 In DATA for a read, the block SHALL count sys_resp_data_valid beats.
REQ-022 The block SHALL enter DONE when the beat count equals len+1.
REQ-023 DONE SHALL last one cycle: pulse req_done for the owner, set rr_ptr to owner+1 (wrapping N_REQ-1 to 0), and return to IDLE.
REQ-024 The grant latency SHALL be 1 cycle from req_valid to sys_req_valid, and back-to-back transactions SHALL be separated by at least DONE plus IDLE (2 cycles).
REQ-025 The block SHALL keep an idle counter, cleared on any ack or beat, that increments in REQ and DATA.
REQ-026 When the idle counter reaches TIMEOUT, the block SHALL go to DONE, pulse req_err instead of req_done, deassert all bus outputs, and still advance rr_ptr.
REQ-027 req_ack and resp_valid SHALL be combinational gates of the bus inputs on the owner's one-hot grant, and SHALL be zero outside REQ and DATA respectively.
REQ-028 A requester dropping req_valid during REQ SHALL NOT cancel the transaction; only the timeout aborts it.
REQ-029 Extra write or response beats beyond len+1 SHALL be ignored.
REQ-030 Beats arriving in the same cycle as the ack SHALL be counted.

Reset
REQ-031 While rstn_sys=0 (asynchronous assertion), the block SHALL force state IDLE, rr_ptr=0, counters=0, and all outputs 0.
REQ-032 Deassertion of rstn_sys SHALL be used synchronously to clk.
REQ-033 Reset during REQ or DATA SHALL abandon the transaction without pulsing req_done or req_err.

Structure
REQ-034 FSM state encodings and the beat-count width (3 bits plus carry) SHALL be defined in the shared package mac_mgnt_pkg.
REQ-035 The round-robin selector SHALL be a sub-module rr_arb (N_REQ request bits, rr_ptr input, one-hot grant output) that is purely combinational.

Verification
REQ-036 Requesters 1 and 3 valid together with rr_ptr=0 -> requester 1 is granted, and after its DONE requester 3 is granted and rr_ptr=4%N_REQ=0.
REQ-037 Write from requester 2 with addr=0x10, len=1, ack after 3 cycles, bytes 0xAA and 0x55 -> sys_req_data carries 0xAA then 0x55, and req_done[2] pulses once.
REQ-038 Read from requester 0 with len=3 -> 4 sys_resp_data_valid beats appear only on resp_valid[0], and resp_valid[1..3]=0 throughout.
REQ-039 ack never returned with TIMEOUT=15 -> req_err pulses 16 cycles after sys_req_valid rises, and the next requester is then granted.
REQ-040 rstn_sys pulsed low mid-DATA -> all outputs are 0 immediately, the block is in IDLE after release, and no done or err pulse occurs.
REQ-041 A 5th write beat arrives with len=3 -> the beat is not forwarded, and the FSM has already left DATA.
